// File: rtl/ffa_arbiter_if.sv
// Bundle between the requesters, the shared finite field adder and the arbiter.
// The master modport is the client/FFA side; the slave modport is the arbiter.
interface ffa_arbiter_if #(
    parameter int W    = 256,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 4,
    parameter int CW   = $clog2(LAT + 2) + 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_gnt;
    logic [W-1:0]      ffa_a;
    logic [W-1:0]      ffa_b;
    logic [W-1:0]      ffa_sum;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic [CW-1:0]     inflight;

    modport master (
        output req_valid, req_a, req_b, ffa_sum,
        input  req_gnt, ffa_a, ffa_b, rsp_valid, rsp_id, rsp_sum, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, ffa_sum,
        output req_gnt, ffa_a, ffa_b, rsp_valid, rsp_id, rsp_sum, inflight
    );
endinterface

// File: rtl/ffa_arbiter.sv
// Round-robin scheduler sharing one fully pipelined GF(p) adder among NREQ clients.
// A tag shift register follows each issued pair so its sum returns to the right client.
module ffa_arbiter #(
    parameter int W    = 256,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 4
) (
    input  logic         clk,
    input  logic         reset,
    ffa_arbiter_if.slave bus
);
    localparam int CW = $clog2(LAT + 2) + 1;
    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

    logic [IDW-1:0]          last_gnt_q, last_gnt_d;
    logic [W-1:0]            ffa_a_q, ffa_a_d;
    logic [W-1:0]            ffa_b_q, ffa_b_d;
    logic [LAT:0]            tag_vld_q, tag_vld_d;
    logic [LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]          rsp_id_q, rsp_id_d;
    logic [W-1:0]            rsp_sum_q, rsp_sum_d;
    logic [CW-1:0]           inflight_q, inflight_d;

    logic [NREQ-1:0]         gnt_s;
    logic                    gnt_any_s;
    logic [IDW-1:0]          gnt_id_s;
    logic [IDW-1:0]          idx_s;
    logic                    hit_s;
    logic                    launch_s;

    // Round-robin pick: first pending requester after the last winner, none in reset
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_id_s  = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s     = IDW'((int'(last_gnt_q) + k) % NREQ);
            hit_s     = !reset && !gnt_any_s && bus.req_valid[idx_s];
            gnt_id_s  = hit_s ? idx_s : gnt_id_s;
            gnt_any_s = gnt_any_s | hit_s;
        end
        gnt_s = gnt_any_s ? (NREQ'(1) << gnt_id_s) : '0;
    end

    // Next-state for issue, tag pipeline, return stage and occupancy counter
    always_comb begin
        launch_s    = tag_vld_q[LAT];
        last_gnt_d  = gnt_any_s ? gnt_id_s : last_gnt_q;
        ffa_a_d     = gnt_any_s ? bus.req_a[int'(gnt_id_s) * W +: W] : ffa_a_q;
        ffa_b_d     = gnt_any_s ? bus.req_b[int'(gnt_id_s) * W +: W] : ffa_b_q;
        tag_vld_d   = {tag_vld_q[LAT-1:0], gnt_any_s};
        tag_id_d    = {tag_id_q[LAT-1:0], gnt_id_s};
        rsp_valid_d = launch_s;
        rsp_sum_d   = launch_s ? bus.ffa_sum : rsp_sum_q;
        rsp_id_d    = launch_s ? tag_id_q[LAT] : rsp_id_q;
        // An op stays counted until the cycle its response is presented has ended
        inflight_d  = inflight_q + CW'(gnt_any_s) - CW'(rsp_valid_q);
    end

    // State registers; reset discards every in-flight tag
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q  <= PTR_RST;
            ffa_a_q     <= '0;
            ffa_b_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            inflight_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            ffa_a_q     <= ffa_a_d;
            ffa_b_q     <= ffa_b_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            inflight_q  <= inflight_d;
        end
    end

    assign bus.req_gnt   = gnt_s;
    assign bus.ffa_a     = ffa_a_q;
    assign bus.ffa_b     = ffa_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.inflight  = inflight_q;
endmodule

// File: doc/ffa_arbiter.md
Name: ffa_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one pipelined 256-bit GF(p) finite field adder (FFA) between NREQ requesters.
- Accepts one operand pair per cycle, drives the adder inputs, and tracks each in-flight operation with a tag shift register.
- Returns each adder result to its originating requester.
- Sits between client datapaths (e.g. point-arithmetic sequencers) and the single FFA instance.

Parameters:
- W, 256, operand/result width; must equal the FFA width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; clog2(NREQ).
- LAT, 4, FFA latency: cycles from ffa_a/ffa_b driven to ffa_sum valid.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has an operand pair pending.
- req_a  in  NREQ*W  packed operand a; slice i = [i*W +: W].
- req_b  in  NREQ*W  packed operand b, same packing.
- req_gnt  out  NREQ  one-hot, combinational; pair i accepted this cycle.
- ffa_a  out  W  registered operand a to the FFA.
- ffa_b  out  W  registered operand b to the FFA.
- ffa_sum  in  W  FFA result.
- rsp_valid  out  1  registered; result present on rsp_sum.
- rsp_id  out  IDW  requester the result belongs to.
- rsp_sum  out  W  registered result.
- inflight  out  clog2(LAT+2)+1  number of issued, not yet returned operations.

Behaviour:
- Reset:
  - The only reset is synchronous, active-high `reset`, sampled on the rising edge of `clk`.
  - Clears ffa_a, ffa_b, rsp_sum, rsp_id, rsp_valid and inflight to 0.
  - Clears every tag-pipeline valid bit.
  - Sets the round-robin pointer last_gnt to NREQ-1, so requester 0 has top priority first.
  - req_gnt is 0 while reset is high.
- Arbitration:
  - Combinational round-robin over req_valid, searching from last_gnt+1 upward modulo NREQ.
  - At most one grant per cycle.
  - A request is accepted when req_gnt[i]=1 at a clock edge. Requester i may then change req_a/req_b or drop req_valid in the next cycle.
  - A requester holding req_valid continuously gets a grant every cycle if it is alone, otherwise every NREQ-th cycle at worst.
  - last_gnt updates only on a cycle with a grant.
- Issue stage:
  - On a grant edge, ffa_a/ffa_b load the granted slices.
  - With no grant, ffa_a/ffa_b hold their previous values.
  - A tag {valid=1, id} enters stage 0 of a LAT+1-deep shift register. A non-granting cycle inserts {valid=0}.
  - The tag register shifts every cycle and never stalls. The FFA is fully pipelined, so throughput is 1 op/cycle.
- Return stage:
  - When the tag at stage LAT (the tag issued with the pair on ffa_a/ffa_b LAT cycles earlier) is valid, the next edge does three things:
    - loads rsp_sum<=ffa_sum;
    - loads rsp_id<=tag.id;
    - sets rsp_valid=1 for one cycle.
  - Otherwise rsp_valid=0, and rsp_sum/rsp_id hold.
- Latency: grant in cycle t, then ffa_a/ffa_b valid in t+1, ffa_sum valid in t+1+LAT, rsp_valid high in t+2+LAT.
- Responses have no backpressure. Requesters must sink rsp_valid whenever it is asserted.
- inflight:
  - +1 on each grant, -1 on each rsp_valid launch.
  - Both in the same cycle leaves it unchanged.
  - Maximum value is LAT+2.
- Arithmetic: no arithmetic in the block. The modular reduction is entirely inside the FFA, and W bits pass through unmodified.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid may assert for any operation granted before or during the reset cycle, and inflight returns to 0.
- Out-of-range requests: req_valid bits at index >= NREQ do not exist. Operand slices are used only when granted.

Test Plan:
- Single op: req_valid=4'b0001, req_a[0]=1, req_b[0]=2 at cycle t. Required response: req_gnt=0001 in cycle t, rsp_valid=1 with rsp_id=0 and rsp_sum=3 in cycle t+2+LAT, inflight back to 0 the following cycle.
- Full contention: req_valid=1111 held, operands a=b=i+1 per requester. Required response: grants 0,1,2,3,0 in consecutive cycles; responses arrive in the same order with sums 2,4,6,8,2, back-to-back with no gaps.
- Round-robin fairness: grant requester 2, then raise req_valid=1010. Required response: requester 3 granted before requester 1.
- Throughput: req_valid=0001 held 8 cycles with a=k, b=10 for k=0..7. Required response: 8 consecutive grants; rsp_sum=10..17 on 8 consecutive cycles; inflight peaks at LAT+2.
- Reset mid-flight: issue 3 ops, assert reset for 1 cycle two cycles later. Required response: no rsp_valid for the 3 ops, inflight=0, req_gnt=0 during reset. The next request after reset is served by requester 0 first when 1111 is pending.
- Idle hold: no req_valid for 20 cycles after an op. Required response: ffa_a/ffa_b and rsp_sum hold their last values, rsp_valid stays 0.
